// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants and types for the hazard/forwarding controller.
// Forward-select encodings match the EX operand mux input order.
package hazard_forward_ctrl_pkg;

    localparam int RA_W_DEF  = 5;
    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_e;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle of the hazard/forwarding controller.
// The slave modport is the controller; the master modport is the pipeline.
interface hazard_forward_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  ifid_rs1;
    logic [RA_W-1:0]  ifid_rs2;
    logic             ifid_use1;
    logic             ifid_use2;
    logic [RA_W-1:0]  idex_rs1;
    logic [RA_W-1:0]  idex_rs2;
    logic [RA_W-1:0]  idex_rd;
    logic             idex_regwrite;
    logic             idex_memread;
    logic [RA_W-1:0]  exmem_rd;
    logic             exmem_regwrite;
    logic [RA_W-1:0]  memwb_rd;
    logic             memwb_regwrite;
    logic             branch_taken;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use1, ifid_use2,
        output idex_rs1, idex_rs2, idex_rd, idex_regwrite, idex_memread,
        output exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, branch_taken,
        input  forward_a, forward_b, pc_write, ifid_write, idex_bubble, ifid_flush, stall_cnt
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use1, ifid_use2,
        input  idex_rs1, idex_rs2, idex_rd, idex_regwrite, idex_memread,
        input  exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite, branch_taken,
        output forward_a, forward_b, pc_write, ifid_write, idex_bubble, ifid_flush, stall_cnt
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forward-select for one EX operand: EX/MEM result beats MEM/WB result,
// and register 0 never forwards since it is hard-wired zero.
module hazard_forward_ctrl_fwd_select
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic [RA_W-1:0] i_exmem_rd,
    input  logic            i_exmem_wr,
    input  logic [RA_W-1:0] i_memwb_rd,
    input  logic            i_memwb_wr,
    output logic [1:0]      o_sel
);

    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = i_exmem_wr && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
    assign w_wb_hit = i_memwb_wr && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

    always_comb begin
        o_sel = FWD_NONE;
        if (w_ex_hit)
            o_sel = FWD_EXMEM;
        else if (w_wb_hit)
            o_sel = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding, load-use stall sequencing and branch flush control.
// state    | meaning
// ST_IDLE  | pipeline flowing; a load-use hazard here is stall cycle 1
// ST_STALL | stall cycles 2..LOAD_STALL; r_cnt = stall cycles still to go
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int RA_W       = RA_W_DEF,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL - 1);

    stall_state_e     r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_lu;
    logic             w_hold;

    hazard_forward_ctrl_fwd_select #(.RA_W(RA_W)) u_fwd_a (
        .i_rs       (bus.idex_rs1),
        .i_exmem_rd (bus.exmem_rd),
        .i_exmem_wr (bus.exmem_regwrite),
        .i_memwb_rd (bus.memwb_rd),
        .i_memwb_wr (bus.memwb_regwrite),
        .o_sel      (w_fwd_a)
    );

    hazard_forward_ctrl_fwd_select #(.RA_W(RA_W)) u_fwd_b (
        .i_rs       (bus.idex_rs2),
        .i_exmem_rd (bus.exmem_rd),
        .i_exmem_wr (bus.exmem_regwrite),
        .i_memwb_rd (bus.memwb_rd),
        .i_memwb_wr (bus.memwb_regwrite),
        .o_sel      (w_fwd_b)
    );

    assign w_lu = bus.idex_memread && bus.idex_regwrite && (bus.idex_rd != '0) &&
                  ((bus.ifid_use1 && (bus.ifid_rs1 == bus.idex_rd)) ||
                   (bus.ifid_use2 && (bus.ifid_rs2 == bus.idex_rd)));

    // A taken branch squashes the dependent instruction, so it overrides any stall.
    assign w_hold = !bus.branch_taken && ((r_state == ST_STALL) || w_lu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!bus.branch_taken && w_lu && (LOAD_STALL > 1)) begin
                        r_state <= ST_STALL;
                        r_cnt   <= STALL_RELOAD;
                    end
                end
                ST_STALL: begin
                    if (bus.branch_taken || (r_cnt == 4'd1)) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    // Outputs sit at their reset values for as long as rst_n is held low.
    assign bus.forward_a   = rst_n ? w_fwd_a : FWD_NONE;
    assign bus.forward_b   = rst_n ? w_fwd_b : FWD_NONE;
    assign bus.pc_write    = !rst_n || !w_hold;
    assign bus.ifid_write  = !rst_n || !w_hold;
    assign bus.idex_bubble = rst_n && (w_hold || bus.branch_taken);
    assign bus.ifid_flush  = rst_n && bus.branch_taken;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench: three controller instances (LOAD_STALL 1 and 3, plus a 2-bit stats counter)
// share one stimulus stream; expectations are queued and a negedge monitor compares them.
module tb_hazard_forward_ctrl;

    typedef struct {
        string      name;
        int         dut;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       pcw;
        logic       bub;
        logic       fl;
        int         scnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] t_ifid_rs1, t_ifid_rs2, t_idex_rs1, t_idex_rs2, t_idex_rd, t_exmem_rd, t_memwb_rd;
    logic       t_use1, t_use2, t_idex_wr, t_idex_rd_mem, t_exmem_wr, t_memwb_wr, t_branch;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.RA_W(5), .CNT_W(16)) if0 ();
    hazard_forward_ctrl_if #(.RA_W(5), .CNT_W(16)) if1 ();
    hazard_forward_ctrl_if #(.RA_W(5), .CNT_W(2))  if2 ();

    assign if0.ifid_rs1 = t_ifid_rs1;  assign if1.ifid_rs1 = t_ifid_rs1;  assign if2.ifid_rs1 = t_ifid_rs1;
    assign if0.ifid_rs2 = t_ifid_rs2;  assign if1.ifid_rs2 = t_ifid_rs2;  assign if2.ifid_rs2 = t_ifid_rs2;
    assign if0.ifid_use1 = t_use1;     assign if1.ifid_use1 = t_use1;     assign if2.ifid_use1 = t_use1;
    assign if0.ifid_use2 = t_use2;     assign if1.ifid_use2 = t_use2;     assign if2.ifid_use2 = t_use2;
    assign if0.idex_rs1 = t_idex_rs1;  assign if1.idex_rs1 = t_idex_rs1;  assign if2.idex_rs1 = t_idex_rs1;
    assign if0.idex_rs2 = t_idex_rs2;  assign if1.idex_rs2 = t_idex_rs2;  assign if2.idex_rs2 = t_idex_rs2;
    assign if0.idex_rd = t_idex_rd;    assign if1.idex_rd = t_idex_rd;    assign if2.idex_rd = t_idex_rd;
    assign if0.idex_regwrite = t_idex_wr;     assign if1.idex_regwrite = t_idex_wr;     assign if2.idex_regwrite = t_idex_wr;
    assign if0.idex_memread = t_idex_rd_mem;  assign if1.idex_memread = t_idex_rd_mem;  assign if2.idex_memread = t_idex_rd_mem;
    assign if0.exmem_rd = t_exmem_rd;         assign if1.exmem_rd = t_exmem_rd;         assign if2.exmem_rd = t_exmem_rd;
    assign if0.exmem_regwrite = t_exmem_wr;   assign if1.exmem_regwrite = t_exmem_wr;   assign if2.exmem_regwrite = t_exmem_wr;
    assign if0.memwb_rd = t_memwb_rd;         assign if1.memwb_rd = t_memwb_rd;         assign if2.memwb_rd = t_memwb_rd;
    assign if0.memwb_regwrite = t_memwb_wr;   assign if1.memwb_regwrite = t_memwb_wr;   assign if2.memwb_regwrite = t_memwb_wr;
    assign if0.branch_taken = t_branch;       assign if1.branch_taken = t_branch;       assign if2.branch_taken = t_branch;

    hazard_forward_ctrl #(.RA_W(5), .LOAD_STALL(1), .CNT_W(16)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    hazard_forward_ctrl #(.RA_W(5), .LOAD_STALL(3), .CNT_W(16)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    hazard_forward_ctrl #(.RA_W(5), .LOAD_STALL(1), .CNT_W(2))  u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        t_ifid_rs1 = '0; t_ifid_rs2 = '0; t_use1 = 1'b0; t_use2 = 1'b0;
        t_idex_rs1 = '0; t_idex_rs2 = '0; t_idex_rd = '0; t_idex_wr = 1'b0; t_idex_rd_mem = 1'b0;
        t_exmem_rd = '0; t_exmem_wr = 1'b0; t_memwb_rd = '0; t_memwb_wr = 1'b0; t_branch = 1'b0;
    endtask

    // Load in EX writing x7, instruction in ID reads x7 as rs2.
    task automatic set_lu();
        t_idex_rd_mem = 1'b1; t_idex_wr = 1'b1; t_idex_rd = 5'd7;
        t_ifid_rs2 = 5'd7; t_use2 = 1'b1;
    endtask

    // Load has moved on; a bubble now occupies EX.
    task automatic clear_ex();
        t_idex_rd_mem = 1'b0; t_idex_wr = 1'b0; t_idex_rd = '0;
    endtask

    task automatic chk(input string name, input int dut, input logic [1:0] fa, input logic [1:0] fb,
                       input logic pcw, input logic bub, input logic fl, input int scnt);
        exp_t e;
        e.name = name; e.dut = dut; e.fa = fa; e.fb = fb;
        e.pcw = pcw; e.bub = bub; e.fl = fl; e.scnt = scnt;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string name, input int dut, input int scnt);
        chk(name, dut, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, scnt);
    endtask

    task automatic chk_stall(input string name, input int dut, input int scnt);
        chk(name, dut, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, scnt);
    endtask

    task automatic chk_flush(input string name, input int dut, input int scnt);
        chk(name, dut, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, scnt);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Monitor: every sampled cycle, pop the queued expectations and compare
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t       e;
            logic [1:0] fa, fb;
            logic       pcw, ifw, bub, fl;
            int         sc;
            e = q.pop_front();
            case (e.dut)
                0: begin fa = if0.forward_a; fb = if0.forward_b; pcw = if0.pc_write; ifw = if0.ifid_write;
                         bub = if0.idex_bubble; fl = if0.ifid_flush; sc = int'(if0.stall_cnt); end
                1: begin fa = if1.forward_a; fb = if1.forward_b; pcw = if1.pc_write; ifw = if1.ifid_write;
                         bub = if1.idex_bubble; fl = if1.ifid_flush; sc = int'(if1.stall_cnt); end
                default: begin fa = if2.forward_a; fb = if2.forward_b; pcw = if2.pc_write; ifw = if2.ifid_write;
                         bub = if2.idex_bubble; fl = if2.ifid_flush; sc = int'(if2.stall_cnt); end
            endcase
            n_checks++;
            if (fa !== e.fa || fb !== e.fb || pcw !== e.pcw || ifw !== e.pcw ||
                bub !== e.bub || fl !== e.fl || sc != e.scnt) begin
                n_errors++;
                $display("FAIL %s dut%0d: got fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d, want fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b cnt=%0d",
                         e.name, e.dut, fa, fb, pcw, ifw, bub, fl, sc,
                         e.fa, e.fb, e.pcw, e.pcw, e.bub, e.fl, e.scnt);
            end
        end
    end

    initial begin
        clear_in();
        rst_n = 1'b0;
        step();
        for (int d = 0; d < 3; d++) chk_idle("reset", d, 0);
        step(); rst_n = 1'b1;
        chk_idle("idle", 0, 0);

        // Forwarding priority and x0 handling
        step(); t_exmem_rd = 5'd5; t_exmem_wr = 1'b1; t_memwb_rd = 5'd5; t_memwb_wr = 1'b1;
        t_idex_rs1 = 5'd5; t_idex_rs2 = 5'd3;
        chk("fwd_exmem_pri", 0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 0);
        step(); t_exmem_wr = 1'b0; t_idex_rs2 = 5'd5;
        chk("fwd_memwb", 0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 0);
        step(); t_exmem_wr = 1'b1; t_memwb_rd = 5'd3; t_idex_rs2 = 5'd3;
        chk("fwd_split", 1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 0);
        step(); clear_in(); t_exmem_wr = 1'b1; t_memwb_wr = 1'b1;
        chk_idle("fwd_x0", 0, 0);
        step(); clear_in(); t_memwb_rd = 5'd9; t_idex_rs1 = 5'd9; t_idex_rs2 = 5'd9;
        chk_idle("fwd_wr0", 0, 0);
        step(); t_memwb_wr = 1'b1;
        chk("fwd_memwb_c2", 2, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 0);

        // Load-use stall: 1 cycle on d0/d2, 3 cycles on d1
        step(); clear_in(); set_lu();
        for (int d = 0; d < 3; d++) chk_stall("lu_stall1", d, 0);
        step(); clear_ex();
        chk_idle("lu_release", 0, 1); chk_stall("ls3_stall2", 1, 1); chk_idle("lu_release", 2, 1);
        step();
        chk_idle("lu_hold", 0, 1); chk_stall("ls3_stall3", 1, 2);
        step();
        chk_idle("lu_hold", 0, 1); chk_idle("ls3_done", 1, 3); chk_idle("lu_hold", 2, 1);
        step(); set_lu(); t_use2 = 1'b0; t_use1 = 1'b1; t_ifid_rs1 = 5'd4;
        chk_idle("no_use2", 0, 1); chk_idle("no_use2", 1, 3); chk_idle("no_use2", 2, 1);
        step(); clear_in(); t_idex_rd_mem = 1'b1; t_idex_wr = 1'b1; t_use1 = 1'b1;
        chk_idle("load_x0", 0, 1); chk_idle("load_x0", 1, 3);

        // Branch beats load-use; branch aborts a running stall
        step(); clear_in(); set_lu(); t_branch = 1'b1;
        chk_flush("br_lu", 0, 1); chk_flush("br_lu", 1, 3); chk_flush("br_lu", 2, 1);
        step(); clear_in();
        chk_idle("br_after", 0, 1); chk_idle("br_after", 1, 3);
        step(); set_lu();
        chk_stall("pre_abort", 0, 1); chk_stall("pre_abort", 1, 3); chk_stall("pre_abort", 2, 1);
        step(); clear_in(); t_branch = 1'b1;
        chk_flush("abort", 0, 2); chk_flush("abort", 1, 4); chk_flush("abort", 2, 2);
        step(); clear_in();
        chk_idle("post_abort", 0, 2); chk_idle("post_abort", 1, 4); chk_idle("post_abort", 2, 2);

        // Reset in the middle of a stall
        step(); set_lu();
        chk_stall("pre_rst", 1, 4);
        step(); clear_in();
        chk_stall("pre_rst2", 1, 5);
        step(); rst_n = 1'b0;
        for (int d = 0; d < 3; d++) chk_idle("rst_mid", d, 0);
        step(); rst_n = 1'b1;
        for (int d = 0; d < 3; d++) chk_idle("rst_exit", d, 0);

        // Saturation of the 2-bit stats counter
        for (int k = 1; k <= 5; k++) begin
            step(); clear_in(); set_lu();
            chk_stall("sat_lu", 0, k - 1); chk_stall("sat_lu", 2, imin(k - 1, 3));
            step(); clear_in();
            chk_idle("sat_idle", 0, k); chk_idle("sat_idle", 2, imin(k, 3));
        end

        step();
        for (int i = 0; i < 5 && q.size() > 0; i++) step();
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
